// File: rtl/call_ret_ctrl.sv
// Subroutine call/return sequencer: splits a 2-byte return address into two
// byte pushes on CALL, pops it back on RET, and guards the LIFO against over/underflow.
module call_ret_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 3
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    CALL,
    input  logic                    RET,
    input  logic [2*DATA_WIDTH-1:0] RET_ADDR,
    input  logic [2*DATA_WIDTH-1:0] TARGET,
    output logic [2*DATA_WIDTH-1:0] PC_OUT,
    output logic                    PC_LOAD,
    output logic                    BUSY,
    output logic                    ERR_OVF,
    output logic                    ERR_UNF,
    output logic [DATA_WIDTH-1:0]   STK_WDATA,
    output logic                    STK_CE,
    output logic                    STK_nRW,
    input  logic [DATA_WIDTH-1:0]   STK_RDATA,
    input  logic                    STK_FULL,
    input  logic                    STK_EMPTY,
    output logic [2:0]              DBG_STATE,
    output logic [DEPTH:0]          DBG_COUNT
);

    localparam int AW = 2 * DATA_WIDTH;
    localparam logic [DEPTH:0] ONE      = (DEPTH+1)'(1);
    localparam logic [DEPTH:0] TWO      = (DEPTH+1)'(2);
    localparam logic [DEPTH:0] CALL_MAX = (DEPTH+1)'((1 << DEPTH) - 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PUSH_LO = 3'd1,
        S_PUSH_HI = 3'd2,
        S_POP_HI  = 3'd3,
        S_POP_LO  = 3'd4,
        S_FIN     = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t                state, next_state;
    logic [DEPTH:0]        count;
    logic [AW-1:0]         ret_q;
    logic [AW-1:0]         tgt_q;
    logic [DATA_WIDTH-1:0] hi_q;
    logic [AW-1:0]         pc_q;
    logic                  ovf_q;
    logic                  call_ok;
    logic                  ret_ok;

    assign call_ok = (count <= CALL_MAX) && !STK_FULL;
    assign ret_ok  = (count >= TWO) && !STK_EMPTY;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
            count <= '0;
            ret_q <= '0;
            tgt_q <= '0;
            hi_q  <= '0;
            pc_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (CALL) begin
                        ovf_q <= !call_ok;
                        if (call_ok) begin
                            ret_q <= RET_ADDR;
                            tgt_q <= TARGET;
                        end
                    end else if (RET) begin
                        ovf_q <= 1'b0;
                    end
                end
                S_PUSH_LO: count <= count + ONE;
                S_PUSH_HI: begin
                    count <= count + ONE;
                    pc_q  <= tgt_q;
                end
                S_POP_HI: begin
                    count <= count - ONE;
                    hi_q  <= STK_RDATA;
                end
                S_POP_LO: begin
                    count <= count - ONE;
                    pc_q  <= {hi_q, STK_RDATA};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        STK_CE     = 1'b0;
        STK_nRW    = 1'b0;
        STK_WDATA  = '0;
        case (state)
            S_IDLE: begin
                // CALL has priority; a simultaneous RET is simply dropped.
                if (CALL)     next_state = call_ok ? S_PUSH_LO : S_ERR;
                else if (RET) next_state = ret_ok  ? S_POP_HI  : S_ERR;
            end
            S_PUSH_LO: begin
                STK_CE     = 1'b1;
                STK_nRW    = 1'b1;
                STK_WDATA  = ret_q[DATA_WIDTH-1:0];
                next_state = S_PUSH_HI;
            end
            S_PUSH_HI: begin
                STK_CE     = 1'b1;
                STK_nRW    = 1'b1;
                STK_WDATA  = ret_q[AW-1:DATA_WIDTH];
                next_state = S_FIN;
            end
            S_POP_HI: begin
                STK_CE     = 1'b1;
                next_state = S_POP_LO;
            end
            S_POP_LO: begin
                STK_CE     = 1'b1;
                next_state = S_FIN;
            end
            S_FIN:   next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign PC_OUT    = pc_q;
    assign PC_LOAD   = (state == S_FIN);
    assign BUSY      = (state != S_IDLE);
    assign ERR_OVF   = (state == S_ERR) && ovf_q;
    assign ERR_UNF   = (state == S_ERR) && !ovf_q;
    assign DBG_STATE = state;
    assign DBG_COUNT = count;

endmodule

// File: tb/tb_call_ret_ctrl.sv
// Bench for call_ret_ctrl: behavioural byte LIFO plus a return-address stack
// model that predicts every stack access, PC load and error pulse.
module tb_call_ret_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        CALL = 1'b0;
    logic        RET = 1'b0;
    logic [15:0] RET_ADDR = '0;
    logic [15:0] TARGET = '0;
    logic [15:0] PC_OUT;
    logic        PC_LOAD, BUSY, ERR_OVF, ERR_UNF;
    logic [7:0]  STK_WDATA;
    logic        STK_CE, STK_nRW;
    logic [7:0]  STK_RDATA;
    logic        STK_FULL, STK_EMPTY;
    logic [2:0]  DBG_STATE;
    logic [3:0]  DBG_COUNT;

    call_ret_ctrl #(.DATA_WIDTH(8), .DEPTH(3)) dut (
        .CLK(CLK), .nRST(nRST), .CALL(CALL), .RET(RET),
        .RET_ADDR(RET_ADDR), .TARGET(TARGET), .PC_OUT(PC_OUT),
        .PC_LOAD(PC_LOAD), .BUSY(BUSY), .ERR_OVF(ERR_OVF), .ERR_UNF(ERR_UNF),
        .STK_WDATA(STK_WDATA), .STK_CE(STK_CE), .STK_nRW(STK_nRW),
        .STK_RDATA(STK_RDATA), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY),
        .DBG_STATE(DBG_STATE), .DBG_COUNT(DBG_COUNT)
    );

    always #5 CLK = ~CLK;

    // Byte-wide LIFO of 8 entries, cleared by the shared reset.
    logic [7:0] smem [8];
    int sp;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) sp <= 0;
        else if (STK_CE) begin
            if (STK_nRW) begin
                if (sp < 8) begin
                    smem[sp] <= STK_WDATA;
                    sp <= sp + 1;
                end
            end else if (sp > 0) begin
                sp <= sp - 1;
            end
        end
    end
    assign STK_RDATA = (sp > 0) ? smem[sp-1] : 8'h00;
    assign STK_FULL  = (sp == 8);
    assign STK_EMPTY = (sp == 0);

    logic [15:0] exp_q[$];
    logic [15:0] last_pc = '0;
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // One request, checked cycle by cycle; hold keeps CALL/RET asserted while busy.
    task automatic run_req(input bit c, input bit r, input logic [15:0] ra,
                           input logic [15:0] tg, input bit hold);
        int frames;
        logic [15:0] e;
        frames = exp_q.size();
        @(negedge CLK);
        CALL = c; RET = r; RET_ADDR = ra; TARGET = tg;
        @(negedge CLK);
        if (!hold) begin CALL = 1'b0; RET = 1'b0; end
        if (c) begin
            if (frames < 4) begin
                check("push_lo_ce", STK_CE, 1);
                check("push_lo_dir", STK_nRW, 1);
                check("push_lo_data", STK_WDATA, ra[7:0]);
                check("push_lo_busy", BUSY, 1);
                @(negedge CLK);
                check("push_hi_ce", STK_CE, 1);
                check("push_hi_dir", STK_nRW, 1);
                check("push_hi_data", STK_WDATA, ra[15:8]);
                @(negedge CLK);
                CALL = 1'b0; RET = 1'b0;
                check("call_pc_load", PC_LOAD, 1);
                check("call_pc_out", PC_OUT, tg);
                check("call_fin_ce", STK_CE, 0);
                exp_q.push_back(ra);
                last_pc = tg;
            end else begin
                CALL = 1'b0; RET = 1'b0;
                check("ovf_pulse", ERR_OVF, 1);
                check("ovf_unf", ERR_UNF, 0);
                check("ovf_busy", BUSY, 1);
                check("ovf_ce", STK_CE, 0);
                check("ovf_pc_load", PC_LOAD, 0);
            end
        end else if (r) begin
            if (frames > 0) begin
                e = exp_q.pop_back();
                check("pop_hi_ce", STK_CE, 1);
                check("pop_hi_dir", STK_nRW, 0);
                @(negedge CLK);
                check("pop_lo_ce", STK_CE, 1);
                check("pop_lo_dir", STK_nRW, 0);
                @(negedge CLK);
                CALL = 1'b0; RET = 1'b0;
                check("ret_pc_load", PC_LOAD, 1);
                check("ret_pc_out", PC_OUT, e);
                last_pc = e;
            end else begin
                CALL = 1'b0; RET = 1'b0;
                check("unf_pulse", ERR_UNF, 1);
                check("unf_ovf", ERR_OVF, 0);
                check("unf_busy", BUSY, 1);
                check("unf_ce", STK_CE, 0);
                check("unf_pc_load", PC_LOAD, 0);
            end
        end
        @(negedge CLK);
        check("idle_busy", BUSY, 0);
        check("idle_pc_load", PC_LOAD, 0);
        check("idle_err", {ERR_OVF, ERR_UNF}, 0);
        check("idle_pc_hold", PC_OUT, last_pc);
        check("idle_count", DBG_COUNT, 2 * exp_q.size());
    endtask

    initial begin
        // Reset held with CALL asserted: everything must stay quiet.
        CALL = 1'b1; RET_ADDR = 16'h1234; TARGET = 16'hABCD;
        repeat (3) @(negedge CLK);
        check("rst_outputs", {PC_OUT, PC_LOAD, BUSY, ERR_OVF, ERR_UNF, STK_WDATA, STK_CE, STK_nRW}, 0);
        check("rst_count", DBG_COUNT, 0);
        CALL = 1'b0;
        nRST = 1'b1;
        @(negedge CLK);
        check("post_rst_busy", BUSY, 0);

        run_req(1, 0, 16'h1234, 16'hABCD, 0);
        run_req(0, 1, 16'h0000, 16'h0000, 0);

        run_req(1, 0, 16'h1111, 16'h0A00, 0);
        run_req(1, 0, 16'h2222, 16'h0B00, 0);
        run_req(1, 0, 16'h3333, 16'h0C00, 0);
        run_req(1, 0, 16'h4444, 16'h0D00, 0);
        run_req(1, 0, 16'h5555, 16'h0E00, 0);
        check("nest_full_count", DBG_COUNT, 8);
        repeat (4) run_req(0, 1, 16'h0000, 16'h0000, 0);

        run_req(0, 1, 16'h0000, 16'h0000, 0);

        // Simultaneous CALL+RET, with CALL held high through the busy window.
        run_req(1, 1, 16'h00FF, 16'h0100, 1);
        check("both_count", DBG_COUNT, 2);
        run_req(0, 1, 16'h0000, 16'h0000, 0);

        // Reset pulse while the high byte is being pushed.
        run_req(1, 0, 16'h7777, 16'h0200, 0);
        @(negedge CLK);
        CALL = 1'b1; RET_ADDR = 16'h9876; TARGET = 16'h0300;
        @(negedge CLK);
        CALL = 1'b0;
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("midrst_busy", BUSY, 0);
        check("midrst_ce", STK_CE, 0);
        check("midrst_count", DBG_COUNT, 0);
        #1;
        nRST = 1'b1;
        exp_q.delete();
        last_pc = '0;
        run_req(0, 1, 16'h0000, 16'h0000, 0);

        for (int i = 0; i < 80; i++) begin
            bit c, r, h;
            c = ($urandom_range(0, 99) < 50);
            r = ($urandom_range(0, 99) < 55);
            h = ($urandom_range(0, 3) == 0);
            run_req(c, r, 16'($urandom), 16'($urandom), h);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
